light_monitor: RTL
==================

LIGHT_MONITOR -- requirements
Module: light_monitor

Interface
REQ-001 The block SHALL have parameter STABLE_CYC, default 4: number of consecutive clk100khz cycles a synchronized value must hold before it is accepted (legal range 1..15).
REQ-002 The block SHALL have parameter RATE_THR, default 30000: interval threshold in clk100khz cycles for fast-rate classification.
REQ-003 The block SHALL have port clk100khz, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port light_in, input, 8 bits: the observed LED bus, asynchronous to clk100khz.
REQ-006 The block SHALL have port locked, output, 1 bit: high while the monitor tracks a valid sequence.
REQ-007 The block SHALL have port phase, output, 2 bits: 0 all-on, 1 shift, 2 alternate, 3 hunting.
REQ-008 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse on each completed frame.
REQ-009 The block SHALL have port err, output, 1 bit: one-cycle pulse on each sequence violation.
REQ-010 The block SHALL have port frame_cnt, output, 8 bits: completed-frame count, saturating.
REQ-011 The block SHALL have port rate_fast, output, 1 bit: last measured step interval below RATE_THR.

Function
REQ-012 light_in SHALL pass through a 2-flop synchronizer; a synchronized value SHALL be accepted when it has been equal for STABLE_CYC consecutive cycles and differs from the last accepted value.
REQ-013 The expected frame SHALL be the 12-entry sequence at index 0..11: FF, 00, 80, 40, 20, 10, 08, 04, 02, 01, AA, 55, with wrap from index 11 back to index 0.
REQ-014 FSM state HUNT: an accepted FF SHALL enter state TRACK at index 0; any other accepted value SHALL be ignored, with no err.
REQ-015 FSM state TRACK: an accepted value equal to expected[(idx+1) mod 12] SHALL advance idx.
REQ-016 In TRACK, any other accepted value SHALL pulse err for one cycle and return to HUNT, except that an accepted FF SHALL pulse err and re-enter TRACK at index 0 in the same cycle.
REQ-017 The 55->FF advance in TRACK SHALL pulse frame_done for one cycle and increment frame_cnt, saturating at 255 with no wrap.
REQ-018 phase SHALL be 3 in HUNT; in TRACK it SHALL be 0 for idx 0, 1 for idx 1..9, and 2 for idx 10..11.
REQ-019 locked SHALL be 1 exactly when the state is TRACK.
REQ-020 All outputs SHALL be registered and SHALL update on the clock edge after the acceptance event.
REQ-021 Total latency from a light_in change to the output update SHALL be 2 + STABLE_CYC + 1 cycles.
REQ-022 A light_in pulse shorter than STABLE_CYC synchronized cycles SHALL be discarded, producing no state change and no err.
REQ-023 A repeated identical value SHALL never produce an acceptance event, so hold duration of any pattern SHALL be irrelevant.

Reset
REQ-024 While rst_n=0, the block SHALL force state HUNT, idx=0, last accepted value=00, synchronizer and stability counter=0, locked=0, phase=3, frame_done=0, err=0, frame_cnt=0, rate_fast=0.
REQ-025 Reset asserted mid-frame SHALL discard all progress, and frame_cnt SHALL clear.
REQ-026 After reset release, the first stable FF SHALL be accepted, because it differs from the reset value 00.

Configuration
REQ-027 With macro LIGHT_MONITOR_RATE_EN defined, a 17-bit interval counter SHALL count cycles between acceptance events, saturating at 131071 and restarting at 1 after each acceptance.
REQ-028 With LIGHT_MONITOR_RATE_EN defined, at each acceptance in TRACK the counter value SHALL be compared with RATE_THR, and rate_fast SHALL be set to 1 if the value is less than RATE_THR, else 0.
REQ-029 With LIGHT_MONITOR_RATE_EN defined, rate_fast SHALL hold its value in HUNT.
REQ-030 Without LIGHT_MONITOR_RATE_EN, the interval counter SHALL be absent and rate_fast SHALL be tied to 0.

Verification
REQ-031 Scenario: after reset, drive FF,00,80,40,20,10,08,04,02,01,AA,55,FF, each held 100 cycles -> locked=1 after the first FF, phase sequence 0,1...1,2,2,0, exactly one frame_done, frame_cnt=1, err never asserted.
REQ-032 Scenario: while in TRACK at idx 3 (value 40), drive 08 -> one err pulse, locked=0, phase=3; a subsequent FF gives locked=1 and phase=0.
REQ-033 Scenario: in TRACK at value 80, drive a 2-cycle glitch to 00 with STABLE_CYC=4 -> no err, idx unchanged.
REQ-034 Scenario: run 300 clean frames -> frame_cnt stays 255 with no wrap, and frame_done still pulses on every frame.
REQ-035 Scenario: with LIGHT_MONITOR_RATE_EN defined, steps every 10000 cycles give rate_fast=1; then steps every 100000 cycles give rate_fast=0 after the first slow step; without the macro, rate_fast=0 throughout.
REQ-036 Scenario: assert rst_n low mid-frame at idx 6 -> all outputs return to reset values asynchronously, and frame_cnt=0.

Source files
------------

// File: rtl/light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : light_monitor
// Purpose  : Tracks a 12-step LED frame sequence on an asynchronous 8-bit bus
//            and reports lock, phase, frame completions and sequence errors.
//            Optional macro LIGHT_MONITOR_RATE_EN adds step-interval timing.
// Revision : 1.0 - initial release
// ============================================================================
module light_monitor #(
    parameter int STABLE_CYC = 4,
    parameter int RATE_THR   = 30000
) (
    input  logic       clk100khz,
    input  logic       rst_n,
    input  logic [7:0] light_in,
    output logic       locked,
    output logic [1:0] phase,
    output logic       frame_done,
    output logic       err,
    output logic [7:0] frame_cnt,
    output logic       rate_fast
);

    typedef enum logic [0:0] {
        S_HUNT  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    localparam logic [3:0] c_STABLE      = 4'(STABLE_CYC);
    localparam logic [3:0] c_LAST_IDX    = 4'd11;
    localparam logic [7:0] c_FRAME_START = 8'hFF;
    localparam logic [7:0] c_CNT_MAX     = 8'hFF;

    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic [7:0] r_cand;
    logic [3:0] r_stab_cnt;
    logic [7:0] r_last;
    logic       w_accept;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_idx;
    logic [3:0] w_idx_nxt;
    logic [3:0] w_idx_inc;
    logic       w_done_nxt;
    logic       w_err_nxt;
    logic [7:0] w_cnt_nxt;

    logic       r_locked;
    logic [1:0] r_phase;
    logic       r_frame_done;
    logic       r_err;
    logic [7:0] r_frame_cnt;

    function automatic logic [7:0] f_expected(input logic [3:0] idx);
        logic [7:0] v;
        case (idx)
            4'd0:    v = 8'hFF;
            4'd1:    v = 8'h00;
            4'd2:    v = 8'h80;
            4'd3:    v = 8'h40;
            4'd4:    v = 8'h20;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h08;
            4'd7:    v = 8'h04;
            4'd8:    v = 8'h02;
            4'd9:    v = 8'h01;
            4'd10:   v = 8'hAA;
            4'd11:   v = 8'h55;
            default: v = 8'hFF;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] f_phase(input state_t st, input logic [3:0] idx);
        logic [1:0] p;
        if (st == S_HUNT)      p = 2'd3;
        else if (idx == 4'd0)  p = 2'd0;
        else if (idx >= 4'd10) p = 2'd2;
        else                   p = 2'd1;
        return p;
    endfunction

    // Input synchronizer and stability filter; a candidate becomes an event
    // once it has held STABLE_CYC cycles and differs from the last event.
    always_ff @(posedge clk100khz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 8'h00;
            r_sync2    <= 8'h00;
            r_cand     <= 8'h00;
            r_stab_cnt <= 4'd0;
            r_last     <= 8'h00;
        end else begin
            r_sync1 <= light_in;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand     <= r_sync2;
                r_stab_cnt <= 4'd1;
            end else if (r_stab_cnt != c_STABLE) begin
                r_stab_cnt <= r_stab_cnt + 4'd1;
            end
            if (w_accept) begin
                r_last <= r_cand;
            end
        end
    end

    assign w_accept  = (r_stab_cnt == c_STABLE) && (r_cand != r_last);
    assign w_idx_inc = (r_idx == c_LAST_IDX) ? 4'd0 : r_idx + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_cnt_nxt   = r_frame_cnt;
        if (w_accept) begin
            case (r_state)
                S_HUNT: begin
                    if (r_cand == c_FRAME_START) begin
                        w_state_nxt = S_TRACK;
                        w_idx_nxt   = 4'd0;
                    end
                end
                S_TRACK: begin
                    if (r_cand == f_expected(w_idx_inc)) begin
                        w_idx_nxt = w_idx_inc;
                        if (r_idx == c_LAST_IDX) begin
                            w_done_nxt = 1'b1;
                            if (r_frame_cnt != c_CNT_MAX) begin
                                w_cnt_nxt = r_frame_cnt + 8'd1;
                            end
                        end
                    end else if (r_cand == c_FRAME_START) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_TRACK;
                        w_idx_nxt   = 4'd0;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_HUNT;
                        w_idx_nxt   = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = S_HUNT;
                    w_idx_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk100khz or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_HUNT;
            r_idx        <= 4'd0;
            r_locked     <= 1'b0;
            r_phase      <= 2'd3;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_locked     <= (w_state_nxt == S_TRACK);
            r_phase      <= f_phase(w_state_nxt, w_idx_nxt);
            r_frame_done <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_frame_cnt  <= w_cnt_nxt;
        end
    end

    assign locked     = r_locked;
    assign phase      = r_phase;
    assign frame_done = r_frame_done;
    assign err        = r_err;
    assign frame_cnt  = r_frame_cnt;

`ifdef LIGHT_MONITOR_RATE_EN
    localparam logic [16:0] c_RATE_THR = 17'(RATE_THR);
    localparam logic [16:0] c_INTV_MAX = 17'h1FFFF;

    logic [16:0] r_interval;
    logic        r_rate_fast;

    // Interval restarts at 1 so its value at the next event equals the
    // number of cycles between the two events.
    always_ff @(posedge clk100khz or negedge rst_n) begin
        if (!rst_n) begin
            r_interval  <= 17'd0;
            r_rate_fast <= 1'b0;
        end else begin
            if (w_accept) begin
                r_interval <= 17'd1;
            end else if (r_interval != c_INTV_MAX) begin
                r_interval <= r_interval + 17'd1;
            end
            if (w_accept && (r_state == S_TRACK)) begin
                r_rate_fast <= (r_interval < c_RATE_THR);
            end
        end
    end

    assign rate_fast = r_rate_fast;
`else
    logic w_unused_rate;
    assign w_unused_rate = ^RATE_THR;
    assign rate_fast     = 1'b0;
`endif

endmodule
`default_nettype wire
